signed_sum_accumulator: RTL and testbench

Downstream consumer of the 6-bit signed adder result. It accepts a stream of two's-complement sums over a valid/ready handshake and accumulates a fixed number of samples into a wider saturating register. It then presents the total on a valid/ready output. It sits between the signed adder datapath and any result sink: display, register file or next arithmetic stage.

---
 rtl/signed_sum_accumulator_pkg.sv | 26 ++
 rtl/signed_sum_accumulator_if.sv | 25 ++
 rtl/signed_sum_accumulator_sat_add.sv | 34 +++
 rtl/signed_sum_accumulator.sv | 105 ++++++++++
 tb/tb_signed_sum_accumulator.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/signed_sum_accumulator_pkg.sv
// Shared types and width helpers for the signed sum accumulator.
package signed_acc_pkg;

  // Control states of the accumulator
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

  // Counter width able to hold values 0..count
  function automatic int cnt_width(input int count);
    return $clog2(count + 1);
  endfunction

  // Largest positive value of an acc_w-bit two's-complement number
  function automatic longint acc_max(input int acc_w);
    return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
  endfunction

  // Most negative value of an acc_w-bit two's-complement number
  function automatic longint acc_min(input int acc_w);
    return -(64'sd1 <<< (acc_w - 1));
  endfunction

endpackage

// File: rtl/signed_sum_accumulator_if.sv
// Sample input stream and result output stream of the accumulator.
interface signed_acc_if #(
  parameter int IN_W  = 6,
  parameter int ACC_W = 10
);
  logic [IN_W-1:0]  In_Data;
  logic             In_Valid;
  logic             In_Ready;
  logic [ACC_W-1:0] Acc_Out;
  logic             Out_Valid;
  logic             Out_Ready;
  logic             Overflow;

  // Producer of samples and consumer of results
  modport master (
    output In_Data, In_Valid, Out_Ready,
    input  In_Ready, Acc_Out, Out_Valid, Overflow
  );

  // The accumulator itself
  modport slave (
    input  In_Data, In_Valid, Out_Ready,
    output In_Ready, Acc_Out, Out_Valid, Overflow
  );
endinterface

// File: rtl/signed_sum_accumulator_sat_add.sv
// Combinational ACC_W-bit signed adder that clamps to the representable range.
module sat_add
  import signed_acc_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(acc_min(ACC_W));

  logic [ACC_W:0] sum_wide_s;

  // Add with one guard bit; differing top two bits mean the true sum is out of range
  always_comb begin
    sum_wide_s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (sum_wide_s[ACC_W] != sum_wide_s[ACC_W-1]) begin
      sat = 1'b1;
      if (sum_wide_s[ACC_W]) begin
        sum = SAT_MIN;
      end else begin
        sum = SAT_MAX;
      end
    end else begin
      sat = 1'b0;
      sum = sum_wide_s[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/signed_sum_accumulator.sv
// Accumulates COUNT signed samples into a saturating register and hands the
// total to a sink over a valid/ready handshake.
module signed_sum_accumulator
  import signed_acc_pkg::*;
#(
  parameter int IN_W  = 6,
  parameter int ACC_W = 10,
  parameter int COUNT = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Clear,
  signed_acc_if.slave  bus
);

  localparam int CNT_W = cnt_width(COUNT);

  acc_state_e       state_r;
  logic [CNT_W-1:0] count_r;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_out_r;
  logic             out_valid_r;
  logic             overflow_r;
  logic             in_ready_r;

  logic [ACC_W-1:0] sample_ext_s;
  logic [ACC_W-1:0] sum_s;
  logic             sat_s;

  assign sample_ext_s = {{(ACC_W-IN_W){bus.In_Data[IN_W-1]}}, bus.In_Data};

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc_r),
    .b   (sample_ext_s),
    .sum (sum_s),
    .sat (sat_s)
  );

  assign bus.In_Ready  = in_ready_r;
  assign bus.Acc_Out   = acc_out_r;
  assign bus.Out_Valid = out_valid_r;
  assign bus.Overflow  = overflow_r;

  // FSM, counter, accumulator and result registers; Clear outranks any handshake
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= IDLE;
      count_r     <= '0;
      acc_r       <= '0;
      acc_out_r   <= '0;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      in_ready_r  <= 1'b1;
    end else if (Clear) begin
      state_r     <= IDLE;
      count_r     <= '0;
      acc_r       <= '0;
      acc_out_r   <= '0;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE, ACCUM: begin
          if (bus.In_Valid) begin
            acc_r      <= sum_s;
            overflow_r <= overflow_r | sat_s;
            count_r    <= count_r + CNT_W'(1);
            if (count_r == CNT_W'(COUNT - 1)) begin
              state_r     <= DONE;
              acc_out_r   <= sum_s;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
            end else begin
              state_r <= ACCUM;
            end
          end else begin
            state_r <= state_r;
          end
        end
        DONE: begin
          if (bus.Out_Ready) begin
            state_r     <= IDLE;
            count_r     <= '0;
            acc_r       <= '0;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          count_r     <= '0;
          acc_r       <= '0;
          out_valid_r <= 1'b0;
          overflow_r  <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_sum_accumulator.sv
// Bench for signed_sum_accumulator: two instances (ACC_W=10 and ACC_W=7) fed
// the same stream and compared against an integer reference model.
module tb_signed_sum_accumulator;

  logic clk;
  logic rst;
  logic clr;

  signed_acc_if #(.IN_W(6), .ACC_W(10)) bus_a ();
  signed_acc_if #(.IN_W(6), .ACC_W(7))  bus_b ();

  signed_sum_accumulator #(.IN_W(6), .ACC_W(10), .COUNT(8)) dut_a (
    .Clk(clk), .Reset(rst), .Clear(clr), .bus(bus_a.slave)
  );

  signed_sum_accumulator #(.IN_W(6), .ACC_W(7), .COUNT(8)) dut_b (
    .Clk(clk), .Reset(rst), .Clear(clr), .bus(bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: samples per result, running sums and flags as plain integers
  int m_cnt;
  bit m_done;
  int m_acc [2];
  int m_out [2];
  bit m_ovf [2];
  int m_max [2] = '{511, 63};
  int m_min [2] = '{-512, -64};

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0;
      m_out[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit v, input int d, input bit rdy, input bit c);
    int s;
    if (c) begin
      model_reset();
    end else if (m_done) begin
      if (rdy) begin
        m_done = 1'b0;
        m_cnt  = 0;
        for (int k = 0; k < 2; k++) begin
          m_acc[k] = 0;
          m_ovf[k] = 1'b0;
        end
      end
    end else if (v) begin
      m_cnt++;
      for (int k = 0; k < 2; k++) begin
        s = m_acc[k] + d;
        if (s > m_max[k]) begin
          s = m_max[k];
          m_ovf[k] = 1'b1;
        end else if (s < m_min[k]) begin
          s = m_min[k];
          m_ovf[k] = 1'b1;
        end
        m_acc[k] = s;
        if (m_cnt == 8) m_out[k] = s;
      end
      if (m_cnt == 8) m_done = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("in_ready_a",  bus_a.In_Ready,  !m_done);
    chk("out_valid_a", bus_a.Out_Valid, m_done);
    chk("acc_out_a",   $signed(bus_a.Acc_Out), m_out[0]);
    chk("overflow_a",  bus_a.Overflow,  m_ovf[0]);
    chk("in_ready_b",  bus_b.In_Ready,  !m_done);
    chk("out_valid_b", bus_b.Out_Valid, m_done);
    chk("acc_out_b",   $signed(bus_b.Acc_Out), m_out[1]);
    chk("overflow_b",  bus_b.Overflow,  m_ovf[1]);
  endtask

  task automatic drive(input bit v, input int d, input bit rdy, input bit c);
    bus_a.In_Valid  = v;
    bus_a.In_Data   = 6'(d);
    bus_a.Out_Ready = rdy;
    bus_b.In_Valid  = v;
    bus_b.In_Data   = 6'(d);
    bus_b.Out_Ready = rdy;
    clr             = c;
  endtask

  // One clock: drive at the falling edge, update the model, check at the next falling edge
  task automatic step(input bit v, input int d, input bit rdy, input bit c);
    drive(v, d, rdy, c);
    model_step(v, d, rdy, c);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic run_n(input int n, input int d, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b1, d, rdy, 1'b0);
  endtask

  task automatic check_async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_rdy_a"}, bus_a.In_Ready, 1'b1);
    chk({tag, "_vld_a"}, bus_a.Out_Valid, 1'b0);
    chk({tag, "_acc_a"}, bus_a.Acc_Out, 10'h000);
    chk({tag, "_ovf_a"}, bus_a.Overflow, 1'b0);
    chk({tag, "_vld_b"}, bus_b.Out_Valid, 1'b0);
    chk({tag, "_acc_b"}, bus_b.Acc_Out, 7'h00);
    model_reset();
    drive(1'b0, 0, 1'b1, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready",  bus_a.In_Ready,  1'b1);
    chk("rst_out_valid", bus_a.Out_Valid, 1'b0);
    chk("rst_acc_out",   bus_a.Acc_Out,   10'h000);
    chk("rst_overflow",  bus_a.Overflow,  1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_all();

    // 8 x +5 back-to-back with the sink always ready
    run_n(8, 5, 1'b1);
    chk("p5_valid", bus_a.Out_Valid, 1'b1);
    chk("p5_acc",   $signed(bus_a.Acc_Out), 40);
    chk("p5_ovf",   bus_a.Overflow, 1'b0);
    chk("p5_ready_low", bus_a.In_Ready, 1'b0);
    step(1'b1, 5, 1'b1, 1'b0);
    chk("p5_ready_back", bus_a.In_Ready, 1'b1);
    chk("p5_valid_drop", bus_a.Out_Valid, 1'b0);

    // 8 x -32: most negative sample, no saturation at ACC_W=10
    run_n(8, -32, 1'b1);
    chk("m32_acc",  bus_a.Acc_Out, 10'h300);
    chk("m32_ovf",  bus_a.Overflow, 1'b0);
    chk("m32_acc7", $signed(bus_b.Acc_Out), -64);
    chk("m32_ovf7", bus_b.Overflow, 1'b1);
    step(1'b0, 0, 1'b1, 1'b0);

    // 8 x +31 saturates the narrow instance, next result starts clean
    run_n(8, 31, 1'b1);
    chk("p31_acc7", $signed(bus_b.Acc_Out), 63);
    chk("p31_ovf7", bus_b.Overflow, 1'b1);
    chk("p31_acc",  $signed(bus_a.Acc_Out), 248);
    step(1'b0, 0, 1'b1, 1'b0);
    run_n(8, 1, 1'b1);
    chk("p1_acc7", $signed(bus_b.Acc_Out), 8);
    chk("p1_ovf7", bus_b.Overflow, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);

    // Backpressure: result held for 5 cycles while samples are offered
    run_n(8, 3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, int'($urandom_range(0, 63)) - 32, 1'b0, 1'b0);
      chk("bp_acc",   $signed(bus_a.Acc_Out), 24);
      chk("bp_valid", bus_a.Out_Valid, 1'b1);
      chk("bp_ready", bus_a.In_Ready, 1'b0);
    end
    step(1'b0, 0, 1'b1, 1'b0);
    chk("bp_release_ready", bus_a.In_Ready, 1'b1);
    chk("bp_release_valid", bus_a.Out_Valid, 1'b0);

    // Clear after 3 accepts of +7, coinciding with a valid sample
    run_n(3, 7, 1'b1);
    step(1'b1, 7, 1'b1, 1'b1);
    run_n(8, 1, 1'b1);
    chk("clr_acc", $signed(bus_a.Acc_Out), 8);
    step(1'b0, 0, 1'b1, 1'b0);

    // Asynchronous reset mid-accumulation, then mid-result
    run_n(4, 9, 1'b1);
    check_async_reset("arst_accum");
    run_n(8, 2, 1'b0);
    chk("pre_arst_done", bus_a.Out_Valid, 1'b1);
    check_async_reset("arst_done");
    run_n(8, 4, 1'b1);
    chk("post_arst_acc", $signed(bus_a.Acc_Out), 32);
    step(1'b0, 0, 1'b1, 1'b0);

    // Random traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 63)) - 32,
           $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
